// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the multi-digit BCD counter family.
package bcd_pkg;

  localparam int             BCD_DIGIT_W   = 4;
  localparam logic [3:0]     BCD_MAX_DIGIT = 4'd9;
  localparam int             BCD_MAX_DIGITS = 8;

  // Decimal integer to packed BCD, digit 0 in bits [3:0]; callers slice to their width.
  function automatic logic [BCD_MAX_DIGITS*BCD_DIGIT_W-1:0] to_bcd(input int unsigned val);
    logic [BCD_MAX_DIGITS*BCD_DIGIT_W-1:0] r;
    int unsigned v;
    r = '0;
    v = val;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: steps up or down when enabled and the lower decades carry/borrow in.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic                   en,
  input  logic                   up,
  input  logic                   cin,
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] nxt,
  output logic                   cout
);

  always_comb begin
    nxt  = digit;
    cout = 1'b0;
    if (en && cin) begin
      if (up) begin
        if (digit == BCD_MAX_DIGIT) begin
          nxt  = '0;
          cout = 1'b1;
        end else begin
          nxt = digit + 1'b1;
        end
      end else begin
        if (digit == '0) begin
          nxt  = BCD_MAX_DIGIT;
          cout = 1'b1;
        end else begin
          nxt = digit - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Parametrised up/down BCD counter with load, terminal wrap and registered TC pulse.
// Define BCD_COUNTER_SAT_EN to saturate at the ends instead of wrapping.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int MAX_COUNT = 99
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          EN,
  input  logic                          UP,
  input  logic                          LOAD,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] LOAD_VAL,
  output logic [BCD_DIGIT_W*DIGITS-1:0] BCD,
  output logic                          TC
);

  localparam int W = BCD_DIGIT_W * DIGITS;
  localparam logic [BCD_MAX_DIGITS*BCD_DIGIT_W-1:0] MAX_FULL = to_bcd(MAX_COUNT);
  localparam logic [W-1:0] MAX_BCD = MAX_FULL[W-1:0];

  logic [W-1:0] step_val;
  logic [W-1:0] san_val;
  logic [W-1:0] load_bcd;
  logic         at_max;
  logic         top_cout;
  logic         wrap_hit;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic cin;
    logic cout;
    if (i == 0) begin : g_lsd
      assign cin = 1'b1;
    end else begin : g_chain
      assign cin = g_dig[i-1].cout;
    end

    bcd_digit u_digit (
      .en    (EN),
      .up    (UP),
      .cin   (cin),
      .digit (BCD[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .nxt   (step_val[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .cout  (cout)
    );

    assign san_val[i*BCD_DIGIT_W +: BCD_DIGIT_W] =
      (LOAD_VAL[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) ?
        '0 : LOAD_VAL[i*BCD_DIGIT_W +: BCD_DIGIT_W];
  end

  // With every nibble <= 9, plain unsigned compare orders BCD values correctly.
  assign load_bcd = (san_val > MAX_BCD) ? MAX_BCD : san_val;
  assign at_max   = (BCD == MAX_BCD);
  // A borrow out of the top decade only happens when counting down from all-zero.
  assign top_cout = g_dig[DIGITS-1].cout;
  assign wrap_hit = UP ? at_max : top_cout;

`ifdef BCD_COUNTER_SAT_EN
  logic sat_seen;

  always_ff @(posedge CLK) begin
    if (RST) begin
      BCD      <= '0;
      TC       <= 1'b0;
      sat_seen <= 1'b0;
    end else if (LOAD) begin
      BCD      <= load_bcd;
      TC       <= 1'b0;
      sat_seen <= 1'b0;
    end else if (EN) begin
      if (wrap_hit) begin
        // Hold at the end; only the first blocked step is reported.
        TC       <= ~sat_seen;
        sat_seen <= 1'b1;
      end else begin
        BCD      <= step_val;
        TC       <= 1'b0;
        sat_seen <= 1'b0;
      end
    end else begin
      TC <= 1'b0;
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (RST) begin
      BCD <= '0;
      TC  <= 1'b0;
    end else if (LOAD) begin
      BCD <= load_bcd;
      TC  <= 1'b0;
    end else if (EN) begin
      if (wrap_hit) begin
        BCD <= UP ? '0 : MAX_BCD;
        TC  <= 1'b1;
      end else begin
        BCD <= step_val;
        TC  <= 1'b0;
      end
    end else begin
      TC <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Randomised bench for bcd_updown_counter: integer reference model plus pinned literal checks.
module tb_bcd_updown_counter;
  import bcd_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up;
  logic        load;
  logic [11:0] load_val;
  logic [7:0]  a_bcd, b_bcd;
  logic [11:0] c_bcd;
  logic        a_tc, b_tc, c_tc;

  int n_chk;
  int n_fail;
  bit chk_en;

  int unsigned m_val [3];
  bit          m_tc  [3];
  bit          m_sat [3];
  int unsigned mx [3] = '{99, 59, 407};
  int          dg [3] = '{2, 2, 3};

  bcd_updown_counter #(.DIGITS(2), .MAX_COUNT(99)) u_a (
    .CLK(clk), .RST(rst), .EN(en), .UP(up), .LOAD(load),
    .LOAD_VAL(load_val[7:0]), .BCD(a_bcd), .TC(a_tc));
  bcd_updown_counter #(.DIGITS(2), .MAX_COUNT(59)) u_b (
    .CLK(clk), .RST(rst), .EN(en), .UP(up), .LOAD(load),
    .LOAD_VAL(load_val[7:0]), .BCD(b_bcd), .TC(b_tc));
  bcd_updown_counter #(.DIGITS(3), .MAX_COUNT(407)) u_c (
    .CLK(clk), .RST(rst), .EN(en), .UP(up), .LOAD(load),
    .LOAD_VAL(load_val), .BCD(c_bcd), .TC(c_tc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned sanitize(input logic [11:0] lv, input int digits,
                                           input int unsigned lim);
    int unsigned n = 0;
    int unsigned p = 1;
    int unsigned d;
    for (int i = 0; i < digits; i++) begin
      d = 32'(lv[i*4 +: 4]);
      if (d > 9) d = 0;
      n += d * p;
      p *= 10;
    end
    return (n > lim) ? lim : n;
  endfunction

  // Reference model in plain integers.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_val[k] = 0; m_tc[k] = 0; m_sat[k] = 0;
      end else if (load) begin
        m_val[k] = sanitize(load_val, dg[k], mx[k]); m_tc[k] = 0; m_sat[k] = 0;
      end else if (en) begin
        if (up ? (m_val[k] == mx[k]) : (m_val[k] == 0)) begin
`ifdef BCD_COUNTER_SAT_EN
          m_tc[k] = !m_sat[k]; m_sat[k] = 1;
`else
          m_val[k] = up ? 0 : mx[k]; m_tc[k] = 1;
`endif
        end else begin
          m_val[k] = up ? m_val[k] + 1 : m_val[k] - 1; m_tc[k] = 0; m_sat[k] = 0;
        end
      end else begin
        m_tc[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (chk_en) begin
      e = to_bcd(m_val[0]); chk("a_bcd", {24'h0, a_bcd}, {24'h0, e[7:0]});
      chk("a_tc", {31'h0, a_tc}, {31'h0, m_tc[0]});
      e = to_bcd(m_val[1]); chk("b_bcd", {24'h0, b_bcd}, {24'h0, e[7:0]});
      chk("b_tc", {31'h0, b_tc}, {31'h0, m_tc[1]});
      e = to_bcd(m_val[2]); chk("c_bcd", {20'h0, c_bcd}, {20'h0, e[11:0]});
      chk("c_tc", {31'h0, c_tc}, {31'h0, m_tc[2]});
    end
  end

  task automatic tick(input logic r, input logic e, input logic u, input logic l,
                      input logic [11:0] v);
    rst = r; en = e; up = u; load = l; load_val = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int tc_cnt;
    n_chk = 0; n_fail = 0; chk_en = 0;
    rst = 1; en = 0; up = 0; load = 0; load_val = '0;

    // Reset with other inputs active
    tick(1, 1, 1, 1, 12'h123);
    tick(1, 1, 1, 0, 12'h000);
    tick(1, 0, 0, 0, 12'h000);
    chk_en = 1;
    chk("rst_a_bcd", {24'h0, a_bcd}, 32'h00);
    chk("rst_a_tc", {31'h0, a_tc}, 32'h0);

    // Count up 100 cycles through 99 and back to 00
    tc_cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      tick(0, 1, 1, 0, 12'h000);
      if (a_tc) tc_cnt++;
      if (i == 99) chk("up_99", {24'h0, a_bcd}, 32'h99);
    end
    chk("up_wrap_00", {24'h0, a_bcd}, 32'h00);
    chk("up_wrap_tc", {31'h0, a_tc}, 32'h1);
    chk("up_tc_once", tc_cnt, 32'd1);
    chk("c_100", {20'h0, c_bcd}, 32'h100);

    // Down wrap / saturate at 0
    tick(0, 0, 0, 1, 12'h000);
    tick(0, 1, 0, 0, 12'h000);
`ifdef BCD_COUNTER_SAT_EN
    chk("dn_sat_b", {24'h0, b_bcd}, 32'h00);
    chk("dn_sat_tc", {31'h0, b_tc}, 32'h1);
    tick(0, 1, 0, 0, 12'h000);
    chk("dn_sat_b2", {24'h0, b_bcd}, 32'h00);
`else
    chk("dn_wrap_b", {24'h0, b_bcd}, 32'h59);
    chk("dn_wrap_tc", {31'h0, b_tc}, 32'h1);
    tick(0, 1, 0, 0, 12'h000);
    chk("dn_58", {24'h0, b_bcd}, 32'h58);
`endif
    chk("dn_tc_low", {31'h0, b_tc}, 32'h0);

    // Load priority and sanitising
    tick(0, 1, 1, 1, 12'h07A);
    chk("ld_7a", {24'h0, a_bcd}, 32'h70);
    chk("ld_7a_tc", {31'h0, a_tc}, 32'h0);
    tick(0, 1, 0, 1, 12'h085);
    chk("ld_85_clamp", {24'h0, b_bcd}, 32'h59);
    chk("ld_85_a", {24'h0, a_bcd}, 32'h85);
    chk("ld_85_tc", {31'h0, b_tc}, 32'h0);

    // Direction toggle, then hold
    tick(0, 0, 0, 1, 12'h045);
    tick(0, 1, 1, 0, 12'h000); chk("dir_46", {24'h0, a_bcd}, 32'h46);
    tick(0, 1, 0, 0, 12'h000); chk("dir_45", {24'h0, a_bcd}, 32'h45);
    tick(0, 1, 1, 0, 12'h000); chk("dir_46b", {24'h0, a_bcd}, 32'h46);
    tick(0, 1, 0, 0, 12'h000); chk("dir_45b", {24'h0, a_bcd}, 32'h45);
    tick(0, 0, 1, 0, 12'h000); chk("hold_45", {24'h0, a_bcd}, 32'h45);
    chk("hold_tc", {31'h0, a_tc}, 32'h0);

    // Reset beats load mid-count
    tick(0, 0, 0, 1, 12'h037);
    tick(1, 1, 1, 1, 12'h037);
    chk("mid_rst", {24'h0, a_bcd}, 32'h00);
    tick(0, 1, 1, 0, 12'h000);
    chk("after_rst", {24'h0, a_bcd}, 32'h01);

    // Behaviour past the top
    tick(0, 0, 0, 1, 12'h099);
    tick(0, 1, 1, 0, 12'h000);
`ifdef BCD_COUNTER_SAT_EN
    chk("sat_99_1", {24'h0, a_bcd}, 32'h99); chk("sat_tc_1", {31'h0, a_tc}, 32'h1);
    tick(0, 1, 1, 0, 12'h000);
    chk("sat_99_2", {24'h0, a_bcd}, 32'h99); chk("sat_tc_2", {31'h0, a_tc}, 32'h0);
    tick(0, 1, 1, 0, 12'h000);
    chk("sat_99_3", {24'h0, a_bcd}, 32'h99); chk("sat_tc_3", {31'h0, a_tc}, 32'h0);
`else
    chk("wrap_00", {24'h0, a_bcd}, 32'h00); chk("wrap_tc_1", {31'h0, a_tc}, 32'h1);
    tick(0, 1, 1, 0, 12'h000);
    chk("wrap_01", {24'h0, a_bcd}, 32'h01); chk("wrap_tc_2", {31'h0, a_tc}, 32'h0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(63) == 0), ($urandom_range(3) != 0), 1'($urandom),
           ($urandom_range(7) == 0), 12'($urandom));
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised multi-digit BCD counter; successor to the fixed two-digit BCD counter.
- Adds: configurable digit count and terminal value; up/down direction; count enable; synchronous parallel load; registered wrap pulse.
- Drives 7-segment display decoders and timebase chains (TC cascades into the next counter's EN).

Parameters:
- DIGITS, 2, number of BCD decades (1..8).
- MAX_COUNT, 99, terminal value as a decimal integer; must satisfy 0 < MAX_COUNT < 10^DIGITS.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  count enable; advances one step per cycle while high.
- UP  in  1  direction; 1 = increment, 0 = decrement.
- LOAD  in  1  synchronous parallel load.
- LOAD_VAL  in  4*DIGITS  BCD load value; digit 0 in bits [3:0].
- BCD  out  4*DIGITS  current count in BCD; digit 0 in bits [3:0].
- TC  out  1  registered one-cycle wrap pulse.

Behaviour:
- Priority each rising edge: RST > LOAD > EN > hold.
- Reset: BCD = 0, TC = 0, regardless of other inputs.
- Load:
  - Any LOAD_VAL nibble above 9 is replaced by 0.
  - If the sanitised value exceeds MAX_COUNT, MAX_COUNT is loaded instead.
  - TC = 0 on a load cycle.
  - Load overrides EN in the same cycle.
- Count up (EN=1, UP=1):
  - Below MAX_COUNT: value + 1.
  - At MAX_COUNT: wraps to 0 and TC = 1 for the next cycle.
- Count down (EN=1, UP=0):
  - Above 0: value − 1.
  - At 0: wraps to MAX_COUNT and TC = 1 for the next cycle.
- Per-digit arithmetic:
  - Increment: digit 9 with carry-in → 0 with carry-out.
  - Decrement: digit 0 with borrow-in → 9 with borrow-out.
  - Terminal detection compares the whole vector against the BCD encoding of MAX_COUNT. Digits are not wrapped individually at the MAX_COUNT digits; MAX_COUNT = 59 wraps 59→00, not 59→50.
- Hold (EN=0, no load): BCD unchanged; TC = 0.
- Latency: BCD and TC update one cycle after the sampled inputs; no combinational path from inputs to outputs.
- UP may change on any cycle; it takes effect on the same edge it is sampled.
- RST asserted mid-count clears BCD and TC on that edge; counting resumes from 0 on the first edge with RST low and EN high.
- BCD never holds a nibble above 9 or a value above MAX_COUNT.

Optional Feature:
- Macro: BCD_COUNTER_SAT_EN.
- Defined:
  - Counter saturates instead of wrapping: up at MAX_COUNT holds MAX_COUNT; down at 0 holds 0.
  - TC pulses once, on the first saturating attempt only.
  - TC re-arms after any non-saturating step, load or reset.
- Undefined: wrap behaviour as above; saturation logic is absent from the netlist.

Decomposition:
- Shared package bcd_pkg:
  - Constant BCD_DIGIT_W = 4.
  - Constant BCD_MAX_DIGIT = 9.
  - Function converting a decimal integer to a DIGITS-wide BCD vector; used for the MAX_COUNT encoding and by the bench.
- Sub-module bcd_digit: one decade.
  - Inputs: inc/dec enable, direction, carry/borrow in.
  - Outputs: next digit value, carry/borrow out.
  - Instantiated DIGITS times in a generate chain.
- Terminal compare, load sanitising and TC register live in the top.

Test Plan:
- Reset then count: DIGITS=2, MAX_COUNT=99, RST 3 cycles, EN=1 UP=1 for 100 cycles → BCD runs 00..99, back to 00 on cycle 100; TC high exactly once, in the cycle BCD shows 00.
- Down wrap: MAX_COUNT=59, LOAD_VAL=00, then EN=1 UP=0 → BCD=59 next cycle with TC=1; then 58.
- Load priority and sanitising: LOAD=1 EN=1 LOAD_VAL=8'h7A → BCD=70. LOAD_VAL=8'h85 with MAX_COUNT=59 → BCD=59; TC=0 in both cases.
- Direction change and hold: at BCD=45, toggle UP every cycle with EN=1 → 46, 45, 46, 45. Drop EN → BCD frozen, TC=0.
- Mid-operation reset: RST=1 at BCD=37 while LOAD=1 → BCD=00, TC=0; first EN cycle after release → 01.
- BCD_COUNTER_SAT_EN defined: count up past 99 for 3 extra cycles → BCD stays 99; TC pulses only on the first of those cycles.
